// File: rtl/adder_pkg.sv
// Shared types and helpers for the sequential accumulating adder.
// Build option: define ADDER_SIGNED_EN for two's-complement operands and sums.
package adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

`ifdef ADDER_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (remain > 0) begin
                result = result + 1;
                remain = remain >>> 1;
            end
        end
        return result;
    endfunction

    // Fill bit for widening an operand: its MSB when signed, zero otherwise.
    function automatic logic ext_fill(input logic msb);
        return msb & SIGNED_EN;
    endfunction

endpackage

// File: rtl/acc_stage.sv
// Registered accumulator with clear/load/add controls; clear has priority over load over add.
module acc_stage
    import adder_pkg::*;
#(
    parameter int SUM_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             add,
    input  logic [SUM_W-1:0] operand,
    output logic [SUM_W-1:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= operand;
        end else if (add) begin
            acc <= acc + operand;
        end
    end

endmodule

// File: rtl/seq_accum_adder.sv
// Sums each group of COUNT operands from a valid/ready stream into a widened, registered result.
// Build option: define ADDER_SIGNED_EN for two's-complement operands and sums.
module seq_accum_adder
    import adder_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int COUNT = 4,
    localparam int SUM_W = WIDTH + clog2(COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic             busy
);

    localparam int CNT_W = clog2(COUNT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] ext_data;
    logic [SUM_W-1:0] acc;
    logic             accept;
    logic             last_beat;
    logic             acc_load;
    logic             acc_add;
    logic             acc_clear;
    logic             group_done;

    assign ext_data  = {{(SUM_W - WIDTH){ext_fill(in_data[WIDTH-1])}}, in_data};
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !clear;
    assign last_beat = (cnt == LAST_CNT);
    assign busy      = (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) next_state = ACC;
                ACC:     if (accept && last_beat) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        acc_load   = 1'b0;
        acc_add    = 1'b0;
        group_done = 1'b0;
        case (state)
            IDLE:    acc_load = accept;
            ACC: begin
                acc_add    = accept && !last_beat;
                group_done = accept && last_beat;
            end
            default: ;
        endcase
        acc_clear = clear || group_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                cnt <= CNT_W'(1);
            end else if (last_beat) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    acc_stage #(
        .SUM_W (SUM_W)
    ) u_acc_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (acc_clear),
        .load    (acc_load),
        .add     (acc_add),
        .operand (ext_data),
        .acc     (acc)
    );

    // A completing group overwrites the held result even while it is being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (group_done) begin
            out_valid <= 1'b1;
            out_sum   <= acc + ext_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_accum_adder.sv
// Self-checking bench for seq_accum_adder: directed scenarios plus random traffic against a group-sum model.
module tb_seq_accum_adder;

    localparam int WIDTH = 8;
    localparam int COUNT = 4;
    localparam int SUM_W = 10;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic             busy;

    int tests_run;
    int tests_failed;

    int               grp[$];
    logic             m_valid;
    logic [SUM_W-1:0] m_sum;

    seq_accum_adder #(
        .WIDTH (WIDTH),
        .COUNT (COUNT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic int opValue(input logic [WIDTH-1:0] d);
`ifdef ADDER_SIGNED_EN
        return int'($signed(d));
`else
        return int'(d);
`endif
    endfunction

    function automatic logic [SUM_W-1:0] groupSum();
        int s;
        s = 0;
        foreach (grp[i]) s += grp[i];
        return SUM_W'(s);
    endfunction

    task automatic modelReset();
        grp.delete();
        m_valid = 1'b0;
        m_sum   = '0;
    endtask

    // Advance the model by one clock using the inputs that were present at the edge.
    task automatic modelStep();
        logic ready;
        logic consumed;
        ready    = !m_valid || out_ready;
        consumed = m_valid && out_ready;
        if (clear) begin
            grp.delete();
            m_valid = 1'b0;
        end else begin
            if (in_valid && ready) grp.push_back(opValue(in_data));
            if (grp.size() == COUNT) begin
                m_sum   = groupSum();
                m_valid = 1'b1;
                grp.delete();
            end else if (consumed) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_out_valid"}, 16'(out_valid), 16'(m_valid));
        checkOutput({tag, "_busy"}, 16'(busy), 16'(grp.size() != 0));
        if (m_valid) checkOutput({tag, "_out_sum"}, 16'(out_sum), 16'(m_sum));
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic ordy, input logic clr);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        #1;
        checkOutput("in_ready", 16'(in_ready), 16'(!m_valid || ordy));
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkState("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        clear        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b1;
        modelReset();

        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
        checkOutput("rst_out_sum", 16'(out_sum), 16'd0);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 16'(in_ready), 16'd1);

        // Basic group 1,2,3,4
        applyStimulus(1'b1, 8'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd4, 1'b1, 1'b0);
        checkOutput("basic_sum", 16'(out_sum), 16'd10);
        checkOutput("basic_valid", 16'(out_valid), 16'd1);
        idle(1);
        checkOutput("basic_valid_drop", 16'(out_valid), 16'd0);

        // All-ones operands: one group, then two back-to-back groups
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
        checkOutput("ones_sum", 16'(out_sum), 16'h3FC);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
            checkOutput("b2b_in_ready", 16'(in_ready), 16'd1);
        end
        checkOutput("b2b_sum", 16'(out_sum), 16'h3FC);
        idle(1);

        // Most negative operand when signed, 128 when unsigned: same 10-bit pattern
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h80, 1'b1, 1'b0);
        checkOutput("min_sum", 16'(out_sum), 16'h200);
        idle(1);

        // Backpressure: result held, next group stalled until consumed
        applyStimulus(1'b1, 8'd10, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd20, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd30, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd40, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
            checkOutput("bp_held_sum", 16'(out_sum), 16'd100);
            checkOutput("bp_in_ready", 16'(in_ready), 16'd0);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'd1, 1'b1, 1'b0);
        checkOutput("bp_next_sum", 16'(out_sum), 16'd4);
        idle(1);

        // CLEAR mid-group drops the partial sum and the beat presented with it
        applyStimulus(1'b1, 8'd5, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd6, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd7, 1'b1, 1'b1);
        checkOutput("clr_busy", 16'(busy), 16'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'd1, 1'b1, 1'b0);
        checkOutput("clr_sum", 16'(out_sum), 16'd4);
        idle(1);

        // Asynchronous reset mid-group
        applyStimulus(1'b1, 8'd9, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd9, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_mid_busy", 16'(busy), 16'd0);
        checkOutput("arst_mid_valid", 16'(out_valid), 16'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while a result is held
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'd50, 1'b0, 1'b0);
        checkOutput("arst_pre_valid", 16'(out_valid), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_held_valid", 16'(out_valid), 16'd0);
        checkOutput("arst_held_sum", 16'(out_sum), 16'd0);
        checkOutput("arst_held_busy", 16'(busy), 16'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'd2, 1'b1, 1'b0);
        checkOutput("arst_next_sum", 16'(out_sum), 16'd8);
        idle(1);

        // Random traffic with gaps, backpressure and occasional CLEAR
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7),
                          WIDTH'($urandom()),
                          ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
